// File: rtl/audio_sample_scheduler.sv
// Fractional-accumulator audio sample strobe with one-deep source buffer, attenuation and underrun counting.
// Optional MUTE_ON_UNDERRUN_EN: an underrun outputs zero instead of repeating the previous sample.
module audio_sample_scheduler #(
  parameter int PIXEL_CLK_HZ = 74250000,
  parameter int AUDIO_RATE   = 48000,
  parameter int BIT_WIDTH    = 16
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [3:0]           atten,
  input  logic                 clear_underrun,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [BIT_WIDTH-1:0] src_left,
  input  logic [BIT_WIDTH-1:0] src_right,
  output logic [BIT_WIDTH-1:0] audio_left,
  output logic [BIT_WIDTH-1:0] audio_right,
  output logic                 sample_strobe,
  output logic [7:0]           underrun_count
);

  localparam int ACC_W = $clog2(PIXEL_CLK_HZ) + 1;
  localparam logic [ACC_W-1:0] MOD  = ACC_W'(PIXEL_CLK_HZ);
  localparam logic [ACC_W-1:0] STEP = ACC_W'(AUDIO_RATE);

  generate
    if (AUDIO_RATE <= 0 || AUDIO_RATE >= PIXEL_CLK_HZ) begin : g_bad_rate
      $error("audio_sample_scheduler: AUDIO_RATE must be in (0, PIXEL_CLK_HZ)");
    end
  endgenerate

  typedef enum logic {FETCH, FULL} state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d, sum;
  logic                 primed_q, primed_d;
  logic [BIT_WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [BIT_WIDTH-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic                 strobe_q;
  logic [7:0]           urun_q, urun_d;
  logic                 tick, hs;

  function automatic logic [BIT_WIDTH-1:0] att(input logic [BIT_WIDTH-1:0] x, input logic [3:0] sh);
    return BIT_WIDTH'($signed(x) >>> sh);
  endfunction

  // sum never overflows: acc < MOD and STEP < MOD, so sum < 2*MOD fits ACC_W bits
  always_comb begin
    sum   = acc_q + STEP;
    tick  = 1'b0;
    acc_d = acc_q;
    if (enable) begin
      if (sum >= MOD) begin
        acc_d = sum - MOD;
        tick  = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  assign src_ready = enable && (state_q == FETCH);
  assign hs        = src_valid && src_ready;

  always_comb begin
    state_d  = state_q;
    buf_l_d  = buf_l_q;
    buf_r_d  = buf_r_q;
    out_l_d  = out_l_q;
    out_r_d  = out_r_q;
    urun_d   = urun_q;
    // dropping enable un-primes so the first tick after re-enable is never an underrun
    primed_d = enable ? (primed_q | tick) : 1'b0;
    case (state_q)
      FETCH: begin
        if (hs && tick) begin
          out_l_d = att(src_left, atten);
          out_r_d = att(src_right, atten);
        end else if (hs) begin
          buf_l_d = src_left;
          buf_r_d = src_right;
          state_d = FULL;
        end else if (tick) begin
`ifdef MUTE_ON_UNDERRUN_EN
          out_l_d = '0;
          out_r_d = '0;
`endif
          if (primed_q && urun_q != 8'hFF) urun_d = urun_q + 8'd1;
        end
      end
      FULL: begin
        if (tick) begin
          out_l_d = att(buf_l_q, atten);
          out_r_d = att(buf_r_q, atten);
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    if (clear_underrun) urun_d = 8'd0;
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      state_q  <= FETCH;
      primed_q <= 1'b0;
      buf_l_q  <= '0;
      buf_r_q  <= '0;
      out_l_q  <= '0;
      out_r_q  <= '0;
      strobe_q <= 1'b0;
      urun_q   <= 8'd0;
    end else begin
      acc_q    <= acc_d;
      state_q  <= state_d;
      primed_q <= primed_d;
      buf_l_q  <= buf_l_d;
      buf_r_q  <= buf_r_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
      strobe_q <= tick;
      urun_q   <= urun_d;
    end
  end

  assign audio_left     = out_l_q;
  assign audio_right    = out_r_q;
  assign sample_strobe  = strobe_q;
  assign underrun_count = urun_q;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed bench for audio_sample_scheduler with PIXEL_CLK_HZ=10, AUDIO_RATE=3 (tick gaps 4,3,3).
module tb_audio_sample_scheduler;

  logic        clk_pixel = 1'b0;
  logic        reset, enable, clear_underrun, src_valid, src_ready, sample_strobe;
  logic [3:0]  atten;
  logic [15:0] src_left, src_right, audio_left, audio_right;
  logic [7:0]  underrun_count;

  int n_run  = 0;
  int n_fail = 0;

`ifdef MUTE_ON_UNDERRUN_EN
  localparam logic [15:0] REP_L = 16'h0000, REP_R = 16'h0000;
`else
  localparam logic [15:0] REP_L = 16'h1234, REP_R = 16'h5678;
`endif

  audio_sample_scheduler #(.PIXEL_CLK_HZ(10), .AUDIO_RATE(3), .BIT_WIDTH(16)) dut (
    .clk_pixel(clk_pixel), .reset(reset), .enable(enable), .atten(atten),
    .clear_underrun(clear_underrun), .src_valid(src_valid), .src_ready(src_ready),
    .src_left(src_left), .src_right(src_right), .audio_left(audio_left),
    .audio_right(audio_right), .sample_strobe(sample_strobe), .underrun_count(underrun_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic wait_strobe();
    int k = 0;
    do begin
      step();
      k++;
    end while (!sample_strobe && k < 10);
    if (!sample_strobe) chk("strobe_timeout", 0, 1);
  endtask

  logic [31:0] sched;
  int          seen;

  initial begin
    sched = 32'h0012_4490;  // ticks on enabled edges 4,7,10,14,17,20
    reset = 1'b1; enable = 1'b0; clear_underrun = 1'b0; src_valid = 1'b0;
    atten = 4'd0; src_left = '0; src_right = '0;
    #3;
    chk("rst_left", audio_left, 16'h0);
    chk("rst_right", audio_right, 16'h0);
    chk("rst_strobe", sample_strobe, 0);
    chk("rst_count", underrun_count, 0);
    chk("rst_ready_dis", src_ready, 0);
    step(); step();
    reset = 1'b0;
    enable = 1'b1; src_valid = 1'b1; src_left = 16'h1234; src_right = 16'h5678;

    // cadence with an always-valid source
    for (int n = 1; n <= 20; n++) begin
      step();
      chk($sformatf("strobe@%0d", n), sample_strobe, sched[n]);
      if (n == 1) chk("ready_full", src_ready, 0);
    end
    chk("run_left", audio_left, 16'h1234);
    chk("run_right", audio_right, 16'h5678);
    chk("run_count", underrun_count, 0);

    // three primed underruns at edges 24,27,30
    src_valid = 1'b0;
    for (int n = 21; n <= 30; n++) step();
    chk("urun_count3", underrun_count, 3);
    chk("urun_left", audio_left, REP_L);
    chk("urun_right", audio_right, REP_R);
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
    chk("urun_cleared", underrun_count, 0);

    // on-time handshake exactly on the tick cycle, with attenuation
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step();
      if (n == 4) begin
        chk("unprimed_strobe", sample_strobe, 1);
        chk("unprimed_count", underrun_count, 0);
        chk("unprimed_left", audio_left, 16'h0);
      end
    end
    src_valid = 1'b1; src_left = 16'h8000; src_right = 16'h7FFF; atten = 4'd9;
    step();
    chk("att_strobe", sample_strobe, 1);
    chk("att_left", audio_left, 16'hFFC0);
    chk("att_right", audio_right, 16'h003F);
    chk("att_count", underrun_count, 0);
    chk("att_ready", src_ready, 1);
    src_valid = 1'b0;

    // reset while FULL discards the buffered sample
    src_valid = 1'b1; src_left = 16'h1111; src_right = 16'h2222;
    step();
    chk("full_ready", src_ready, 0);
    src_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_left", audio_left, 16'h0);
    chk("midrst_right", audio_right, 16'h0);
    chk("midrst_ready", src_ready, 1);
    chk("midrst_strobe", sample_strobe, 0);
    step();
    reset = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step();
      if (n == 4) begin
        chk("post_rst_left", audio_left, 16'h0);
        chk("post_rst_count", underrun_count, 0);
      end
    end
    chk("primed_count", underrun_count, 1);

    // enable dropped with acc=4: 100 idle cycles, then tick on 2nd enabled edge
    step();
    enable = 1'b0;
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (sample_strobe) seen++;
    end
    chk("dis_strobes", seen, 0);
    chk("dis_ready", src_ready, 0);
    enable = 1'b1;
    step();
    chk("reen_strobe1", sample_strobe, 0);
    step();
    chk("reen_strobe2", sample_strobe, 1);
    chk("reen_count", underrun_count, 1);

    // saturation, then clear beats a simultaneous underrun
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
    chk("pre_sat_clear", underrun_count, 0);
    for (int n = 0; n < 260; n++) wait_strobe();
    chk("sat_count", underrun_count, 255);
    clear_underrun = 1'b1;
    wait_strobe();
    clear_underrun = 1'b0;
    chk("clear_wins", underrun_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_scheduler.md
Name: audio_sample_scheduler

Overview:
- Generates an exact-average AUDIO_RATE sample strobe from the pixel clock using a fractional accumulator. This replaces a fixed integer divider, which drifts.
- Fetches stereo samples from an audio source over a valid/ready handshake, one sample per strobe period.
- Presents attenuated, registered sample words plus a one-cycle strobe to the HDMI audio packetizer.
- Detects and counts source underruns.

Parameters:
- PIXEL_CLK_HZ, 74250000: pixel clock frequency; accumulator modulus.
- AUDIO_RATE, 48000: output sample rate. Must be greater than 0 and less than PIXEL_CLK_HZ; elaboration error otherwise.
- BIT_WIDTH, 16: sample width per channel, two's complement.

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run control; when low, accumulator and FSM are held.
- atten  in  4  arithmetic right-shift amount applied to output samples (0..15).
- clear_underrun  in  1  synchronous clear of underrun_count.
- src_valid  in  1  source holds a sample.
- src_ready  out  1  scheduler accepts a sample this cycle.
- src_left  in  BIT_WIDTH  left sample from source.
- src_right  in  BIT_WIDTH  right sample from source.
- audio_left  out  BIT_WIDTH  registered left output.
- audio_right  out  BIT_WIDTH  registered right output.
- sample_strobe  out  1  one-cycle pulse; new audio_left/audio_right valid this cycle.
- underrun_count  out  8  saturating count of underruns.

Behaviour:
- Reset (async, active-high): acc=0, state=FETCH, primed=0, buffer=0, audio_left/right=0, sample_strobe=0, underrun_count=0. Reset mid-fetch discards any pending sample.
- Accumulator, per cycle with enable=1:
  - sum = acc + AUDIO_RATE.
  - If sum >= PIXEL_CLK_HZ: acc <= sum - PIXEL_CLK_HZ and internal tick=1.
  - Otherwise acc <= sum and tick=0.
  - Width is clog2(PIXEL_CLK_HZ)+1 bits; no overflow is possible.
  - Consequence: exactly AUDIO_RATE ticks per PIXEL_CLK_HZ enabled cycles, with gaps of floor or ceil of PIXEL_CLK_HZ/AUDIO_RATE only.
- enable=0: acc held, no ticks, src_ready=0, state and outputs held. The primed flag clears, so the first tick after re-enable is never counted as an underrun.
- src_ready = enable and (state==FETCH).
- FSM states:
  - FETCH: buffer empty, src_ready=1. A handshake (src_valid and src_ready) captures src_left/src_right into the buffer and moves to FULL.
  - FULL: buffer holds one sample, src_ready=0.
- On tick, registered, so visible the cycle after the tick:
  - sample_strobe=1.
  - Output source:
    - FULL: output = buffer; state goes to FETCH.
    - FETCH with a handshake in the same cycle: output = the incoming sample directly; counts as on time; state stays FETCH.
    - FETCH with no handshake: underrun. Output is the previous output repeated. underrun_count increments if primed=1, saturating at 255. State stays FETCH.
  - primed <= 1.
- Attenuation: output word = (signed sample) >>> atten, sign-extended, applied per channel at output load. atten is sampled on the tick cycle.
- Latency: tick cycle to sample_strobe is 1 cycle. A sample accepted in period N is output at the tick that ends period N.
- clear_underrun=1: count <= 0. If an underrun occurs in the same cycle, clear wins and count becomes 0.
- sample_strobe is never asserted in two consecutive cycles, because tick spacing is at least 2 when AUDIO_RATE < PIXEL_CLK_HZ/2. If AUDIO_RATE >= PIXEL_CLK_HZ/2, the behaviour is the same with back-to-back strobes permitted.

Optional Feature:
- MUTE_ON_UNDERRUN_EN defined: an underrun outputs 0 on both channels instead of repeating the previous output; underrun counting is unchanged.
- Undefined: the previous output is repeated.

Test Plan:
- PIXEL_CLK_HZ=10, AUDIO_RATE=3, enable high from cycle 1, source always valid -> ticks on enabled cycles 4, 7, 10, 14, 17, 20; sample_strobe one cycle after each; gap pattern 4,3,3 repeating.
- Defaults, 74,250,000 enabled cycles -> exactly 48000 strobes; every gap is 1546 or 1547; first tick on enabled cycle 1547.
- src_valid=0 across three ticks after the first primed tick -> underrun_count=3; outputs repeat the last sample (zero with MUTE_ON_UNDERRUN_EN); clear_underrun -> 0; 260 underruns -> saturates at 255.
- Source asserts src_valid with left=16'h8000, right=16'h7FFF exactly on a tick cycle while in FETCH, atten=9 -> next cycle audio_left=16'hFFC0, audio_right=16'h003F, sample_strobe=1, no underrun counted.
- Assert reset while FULL between ticks -> all outputs 0 immediately, state FETCH, src_ready=1; first tick after release not counted as underrun.
- Drop enable mid-period for 100 cycles -> no strobes, src_ready=0, acc held; tick spacing resumes from the held acc on re-enable.
